// File: rtl/gnw_pkg.sv
// Shared definitions for the segment LCD renderer: FSM states, mask byte layout, segment ids.
// Also holds the H-strobe decode helpers used by the segment store.
package gnw_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_MASK_REQ,
        ST_MASK_WAIT,
        ST_COL_REQ,
        ST_COL_WAIT,
        ST_PUSH,
        ST_FB_REQ,
        ST_FB_WAIT,
        ST_NEXT
    } state_t;

    localparam int MASK_ID_HI  = 7;
    localparam int MASK_ID_LO  = 6;
    localparam int MASK_COL_HI = 5;
    localparam int MASK_COL_LO = 2;
    localparam int MASK_ROW_HI = 1;
    localparam int MASK_ROW_LO = 0;

    localparam logic [1:0] ID_A    = 2'd0;
    localparam logic [1:0] ID_B    = 2'd1;
    localparam logic [1:0] ID_S    = 2'd2;
    localparam logic [1:0] ID_NONE = 2'd3;

    function automatic logic h_is_onehot(input logic [3:0] h);
        return (h == 4'b0001) || (h == 4'b0010) || (h == 4'b0100) || (h == 4'b1000);
    endfunction

    function automatic logic [1:0] h_row(input logic [3:0] h);
        logic [1:0] r;
        r = 2'd0;
        case (h)
            4'b0010: r = 2'd1;
            4'b0100: r = 2'd2;
            4'b1000: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg_latch.sv
// Four-row segment store written by one-hot H strobes, plus a per-frame snapshot cache.
// Capture and snapshot take effect next cycle; lit lookup is combinational from the cache.
module seg_latch
    import gnw_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [15:0] seg_a,
    input  logic [15:0] seg_b,
    input  logic        bs,
    input  logic [3:0]  h,
    input  logic        snap,
    input  logic [7:0]  mask,
    output logic        lit
);

    logic [3:0][15:0] row_a_q, row_a_d;
    logic [3:0][15:0] row_b_q, row_b_d;
    logic [3:0]       row_s_q, row_s_d;
    logic [3:0][15:0] cache_a_q, cache_a_d;
    logic [3:0][15:0] cache_b_q, cache_b_d;
    logic [3:0]       cache_s_q, cache_s_d;

    logic [1:0] m_id;
    logic [3:0] m_col;
    logic [1:0] m_row;

    always_comb begin
        row_a_d   = row_a_q;
        row_b_d   = row_b_q;
        row_s_d   = row_s_q;
        cache_a_d = cache_a_q;
        cache_b_d = cache_b_q;
        cache_s_d = cache_s_q;
        if (h_is_onehot(h)) begin
            row_a_d[h_row(h)] = seg_a;
            row_b_d[h_row(h)] = seg_b;
            row_s_d[h_row(h)] = bs;
        end
        // The snapshot takes the rows as they stood before any same-cycle strobe.
        if (snap) begin
            cache_a_d = row_a_q;
            cache_b_d = row_b_q;
            cache_s_d = row_s_q;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            row_a_q   <= '0;
            row_b_q   <= '0;
            row_s_q   <= '0;
            cache_a_q <= '0;
            cache_b_q <= '0;
            cache_s_q <= '0;
        end else begin
            row_a_q   <= row_a_d;
            row_b_q   <= row_b_d;
            row_s_q   <= row_s_d;
            cache_a_q <= cache_a_d;
            cache_b_q <= cache_b_d;
            cache_s_q <= cache_s_d;
        end
    end

    assign m_id  = mask[MASK_ID_HI:MASK_ID_LO];
    assign m_col = mask[MASK_COL_HI:MASK_COL_LO];
    assign m_row = mask[MASK_ROW_HI:MASK_ROW_LO];

    always_comb begin
        lit = 1'b0;
        case (m_id)
            ID_A:    lit = cache_a_q[m_row][m_col];
            ID_B:    lit = cache_b_q[m_row][m_col];
            ID_S:    lit = cache_s_q[m_row];
            ID_NONE: lit = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_lcd_renderer.sv
// Composites segment LCD pixels (ROM mask/colour records) into packed words for a double-buffered framebuffer.
// Lit pixel 4 cycles, unlit 6 with 1-cycle ROM; each word waits on fb_req/fb_ack, ROM waits on ready.
module seg_lcd_renderer
    import gnw_pkg::*;
#(
    parameter int          IMG_W      = 720,
    parameter int          IMG_H      = 480,
    parameter int          FB_BYTES   = 8,
    parameter logic [24:0] ROM_BASE   = 25'd0,
    parameter logic [27:0] FB_BASE0   = 28'd0,
    parameter logic [27:0] FB_BASE1   = 28'h0080000,
    parameter int          DOUBLE_BUF = 1,
    parameter logic [7:0]  SEG_COLOR  = 8'h00
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic [15:0]           segA,
    input  logic [15:0]           segB,
    input  logic [3:0]            H,
    input  logic                  Bs,
    input  logic                  disp_en,
    output logic [24:0]           rom_img_addr,
    output logic                  rom_img_read,
    input  logic                  rom_img_data_ready,
    input  logic [7:0]            rom_img_data,
    output logic [27:0]           fb_addr,
    output logic [8*FB_BYTES-1:0] fb_data,
    output logic                  fb_req,
    input  logic                  fb_ack,
    output logic                  fb_bank,
    output logic                  frame
);

    localparam int TOTAL = IMG_W * IMG_H;
    localparam int PIX_W = $clog2(TOTAL + 1);
    localparam int BC_W  = $clog2(FB_BYTES);
    localparam int DW    = 8 * FB_BYTES;
    localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(FB_BYTES - 1);
    localparam logic [PIX_W-1:0] LAST_PIX  = PIX_W'(TOTAL);

    if ((TOTAL % FB_BYTES) != 0) begin : g_bad_geometry
        $error("IMG_W*IMG_H must be a multiple of FB_BYTES");
    end
    if (FB_BYTES < 2 || FB_BYTES > 8 || (FB_BYTES & (FB_BYTES - 1)) != 0) begin : g_bad_fb_bytes
        $error("FB_BYTES must be a power of two in 2..8");
    end

    state_t            state_q, state_d;
    logic [24:0]       rom_addr_q, rom_addr_d;
    logic              rom_read_q, rom_read_d;
    logic [27:0]       fb_addr_q, fb_addr_d;
    logic [DW-1:0]     fb_data_q, fb_data_d;
    logic              fb_req_q, fb_req_d;
    logic              fb_bank_q, fb_bank_d;
    logic              wr_bank_q, wr_bank_d;
    logic              frame_q, frame_d;
    logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic              lit_q, lit_d;
    logic [7:0]        pix_q, pix_d;
    logic              snap;
    logic              lit_w;

    seg_latch u_seg_latch (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .seg_a   (segA),
        .seg_b   (segB),
        .bs      (Bs),
        .h       (H),
        .snap    (snap),
        .mask    (rom_img_data),
        .lit     (lit_w)
    );

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        rom_read_d = 1'b0;
        fb_addr_d  = fb_addr_q;
        fb_data_d  = fb_data_q;
        fb_req_d   = fb_req_q;
        fb_bank_d  = fb_bank_q;
        wr_bank_d  = wr_bank_q;
        frame_d    = 1'b0;
        pix_cnt_d  = pix_cnt_q;
        byte_cnt_d = byte_cnt_q;
        lit_d      = lit_q;
        pix_d      = pix_q;
        snap       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (disp_en) begin
                    snap       = (pix_cnt_q == '0);
                    rom_read_d = 1'b1;
                    state_d    = ST_MASK_REQ;
                end
            end
            ST_MASK_REQ: state_d = ST_MASK_WAIT;
            ST_MASK_WAIT: begin
                if (rom_img_data_ready) begin
                    lit_d = lit_w;
                    if (lit_w) begin
                        pix_d   = SEG_COLOR;
                        state_d = ST_PUSH;
                    end else begin
                        rom_addr_d = rom_addr_q + 25'd1;
                        rom_read_d = 1'b1;
                        state_d    = ST_COL_REQ;
                    end
                end
            end
            ST_COL_REQ: state_d = ST_COL_WAIT;
            ST_COL_WAIT: begin
                if (rom_img_data_ready) begin
                    pix_d   = rom_img_data;
                    state_d = ST_PUSH;
                end
            end
            ST_PUSH: begin
                // Lit pixels skipped the colour byte, so they still owe both record bytes.
                fb_data_d  = {pix_q, fb_data_q[DW-1:8]};
                rom_addr_d = rom_addr_q + (lit_q ? 25'd2 : 25'd1);
                pix_cnt_d  = pix_cnt_q + 1'b1;
                byte_cnt_d = byte_cnt_q + 1'b1;
                if (byte_cnt_q == LAST_BYTE) begin
                    fb_req_d = 1'b1;
                    state_d  = ST_FB_REQ;
                end else begin
                    state_d = ST_NEXT;
                end
            end
            ST_FB_REQ, ST_FB_WAIT: begin
                if (fb_ack) begin
                    fb_req_d = 1'b0;
                    if (pix_cnt_q == LAST_PIX) begin
                        frame_d    = 1'b1;
                        fb_bank_d  = wr_bank_q;
                        wr_bank_d  = (DOUBLE_BUF != 0) ? ~wr_bank_q : wr_bank_q;
                        pix_cnt_d  = '0;
                        rom_addr_d = ROM_BASE;
                        fb_addr_d  = wr_bank_d ? FB_BASE1 : FB_BASE0;
                        state_d    = ST_IDLE;
                    end else begin
                        fb_addr_d = fb_addr_q + 28'(FB_BYTES);
                        state_d   = ST_NEXT;
                    end
                end else begin
                    state_d = ST_FB_WAIT;
                end
            end
            ST_NEXT: begin
                if (disp_en) begin
                    rom_read_d = 1'b1;
                    state_d    = ST_MASK_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            rom_addr_q <= ROM_BASE;
            rom_read_q <= 1'b0;
            fb_addr_q  <= FB_BASE0;
            fb_data_q  <= '0;
            fb_req_q   <= 1'b0;
            fb_bank_q  <= 1'b0;
            wr_bank_q  <= 1'b0;
            frame_q    <= 1'b0;
            pix_cnt_q  <= '0;
            byte_cnt_q <= '0;
            lit_q      <= 1'b0;
            pix_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            rom_read_q <= rom_read_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
            fb_req_q   <= fb_req_d;
            fb_bank_q  <= fb_bank_d;
            wr_bank_q  <= wr_bank_d;
            frame_q    <= frame_d;
            pix_cnt_q  <= pix_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            lit_q      <= lit_d;
            pix_q      <= pix_d;
        end
    end

    assign rom_img_addr = rom_addr_q;
    assign rom_img_read = rom_read_q;
    assign fb_addr      = fb_addr_q;
    assign fb_data      = fb_data_q;
    assign fb_req       = fb_req_q;
    assign fb_bank      = fb_bank_q;
    assign frame        = frame_q;

endmodule

// File: tb/tb_seg_lcd_renderer.sv
// Bench for seg_lcd_renderer: ROM and framebuffer responders plus a pixel-level model of each frame.
module tb_seg_lcd_renderer;

    localparam int          IMG_W     = 8;
    localparam int          IMG_H     = 2;
    localparam int          FB_BYTES  = 8;
    localparam int          TOTAL     = IMG_W * IMG_H;
    localparam int          NWORDS    = TOTAL / FB_BYTES;
    localparam logic [24:0] ROM_BASE  = 25'h40;
    localparam logic [27:0] FB_BASE0  = 28'h0;
    localparam logic [27:0] FB_BASE1  = 28'h80;
    localparam logic [7:0]  SEG_COLOR = 8'hA5;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] segA = '0, segB = '0;
    logic [3:0]  H = '0;
    logic        Bs = 1'b0;
    logic        disp_en = 1'b0;
    logic [24:0] rom_img_addr;
    logic        rom_img_read;
    logic        rom_img_data_ready;
    logic [7:0]  rom_img_data;
    logic [27:0] fb_addr;
    logic [63:0] fb_data;
    logic        fb_req;
    logic        fb_ack;
    logic        fb_bank;
    logic        frame;

    always #5 clk_sys = ~clk_sys;

    seg_lcd_renderer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .FB_BYTES(FB_BYTES), .ROM_BASE(ROM_BASE),
        .FB_BASE0(FB_BASE0), .FB_BASE1(FB_BASE1), .DOUBLE_BUF(1), .SEG_COLOR(SEG_COLOR)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .segA(segA), .segB(segB), .H(H), .Bs(Bs),
        .disp_en(disp_en), .rom_img_addr(rom_img_addr), .rom_img_read(rom_img_read),
        .rom_img_data_ready(rom_img_data_ready), .rom_img_data(rom_img_data),
        .fb_addr(fb_addr), .fb_data(fb_data), .fb_req(fb_req), .fb_ack(fb_ack),
        .fb_bank(fb_bank), .frame(frame)
    );

    int nvec = 0;
    int nerr = 0;

    logic [7:0]  rom [2*TOTAL];
    logic [15:0] m_row_a [4], m_row_b [4], m_cache_a [4], m_cache_b [4];
    logic        m_row_s [4], m_cache_s [4];
    int          frame_idx = 0;
    int          slow_idx = -1;
    int          unstable_cnt = 0;
    int          mid_row = 0;

    logic [24:0] rd_addr_q [$];
    logic [27:0] wr_addr_q [$];
    logic [63:0] wr_data_q [$];
    int          held_q [$];

    // ROM: answers each read 1..3 cycles later with the byte at that address.
    initial begin : rom_responder
        rom_img_data_ready = 1'b0;
        rom_img_data = 8'h00;
        forever begin
            @(negedge clk_sys);
            rom_img_data_ready = 1'b0;
            if (reset_n && rom_img_read) begin : serve
                logic [24:0] a;
                int lat;
                int idx;
                a = rom_img_addr;
                rd_addr_q.push_back(a);
                lat = $urandom_range(1, 3);
                repeat (lat) @(negedge clk_sys);
                idx = int'(a - ROM_BASE);
                rom_img_data = (idx < 2*TOTAL) ? rom[idx] : 8'hEE;
                rom_img_data_ready = 1'b1;
            end
        end
    end

    // Framebuffer: captures each request, checks it stays stable, acks after a delay.
    initial begin : fb_responder
        fb_ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            fb_ack = 1'b0;
            if (reset_n && fb_req) begin : serve
                logic [27:0] a;
                logic [63:0] d;
                int dly;
                int held;
                a = fb_addr;
                d = fb_data;
                held = 0;
                dly = (wr_addr_q.size() == slow_idx) ? 10 : $urandom_range(1, 3);
                repeat (dly) begin
                    @(negedge clk_sys);
                    if (fb_req) held++;
                    if (fb_addr !== a || fb_data !== d) unstable_cnt++;
                end
                wr_addr_q.push_back(a);
                wr_data_q.push_back(d);
                held_q.push_back(held);
                fb_ack = 1'b1;
            end
        end
    end

    function automatic bit model_lit(input logic [7:0] m);
        int row;
        int col;
        row = int'(m[1:0]);
        col = int'(m[5:2]);
        case (m[7:6])
            2'd0:    return m_cache_a[row][col];
            2'd1:    return m_cache_b[row][col];
            2'd2:    return m_cache_s[row];
            default: return 1'b0;
        endcase
    endfunction

    task automatic strobe(input logic [3:0] h, input logic [15:0] a, input logic [15:0] b, input logic s);
        @(negedge clk_sys);
        H = h; segA = a; segB = b; Bs = s;
        if ($countones(h) == 1) begin
            m_row_a[$clog2(h)] = a;
            m_row_b[$clog2(h)] = b;
            m_row_s[$clog2(h)] = s;
        end
        @(negedge clk_sys);
        H = 4'b0000;
    endtask

    // mode 0: plain frame; 1: strobes during the frame; 2: slow first ack with disp_en dropped
    task automatic run_frame(input string name, input int mode);
        logic [7:0]  pix [TOTAL];
        logic [24:0] exp_r [$];
        logic [63:0] exp_w;
        logic [27:0] bank_base, next_base;
        logic        bank;
        int base_w, base_r, unst0, cyc, nw, nr, w;
        bit dropped, park_bad;
        for (int i = 0; i < 4; i++) begin
            m_cache_a[i] = m_row_a[i];
            m_cache_b[i] = m_row_b[i];
            m_cache_s[i] = m_row_s[i];
        end
        for (int p = 0; p < TOTAL; p++) begin
            exp_r.push_back(ROM_BASE + 25'(2*p));
            if (model_lit(rom[2*p])) pix[p] = SEG_COLOR;
            else begin
                pix[p] = rom[2*p+1];
                exp_r.push_back(ROM_BASE + 25'(2*p+1));
            end
        end
        bank = frame_idx[0];
        bank_base = bank ? FB_BASE1 : FB_BASE0;
        frame_idx++;
        next_base = frame_idx[0] ? FB_BASE1 : FB_BASE0;
        base_w = wr_addr_q.size();
        base_r = rd_addr_q.size();
        unst0 = unstable_cnt;
        if (mode == 2) slow_idx = base_w;
        dropped = 0;
        disp_en = 1'b1;
        cyc = 0;
        while (cyc < 3000) begin
            @(negedge clk_sys);
            cyc++;
            if (frame) break;
            H = 4'b0000;
            if (mode == 1 && cyc == 30) begin
                H = 4'(1 << mid_row);
                segA = m_row_a[mid_row];
                segB = 16'($urandom);
                Bs = m_row_s[mid_row];
                m_row_b[mid_row] = segB;
            end
            if (mode == 1 && cyc == 40) begin
                H = 4'b0011;
                segA = 16'($urandom);
                segB = 16'($urandom);
            end
            if (mode == 2 && !dropped && fb_req) begin
                disp_en = 1'b0;
                dropped = 1;
                w = 0;
                while (fb_req && w < 50) begin
                    @(negedge clk_sys);
                    w++;
                end
                park_bad = 0;
                repeat (20) begin
                    @(negedge clk_sys);
                    if (rom_img_read !== 1'b0 || fb_req !== 1'b0 || frame !== 1'b0) park_bad = 1;
                end
                nvec++;
                if (park_bad) begin
                    nerr++;
                    $display("FAIL %s park: activity while disp_en low, got 1 expected 0", name);
                end
                disp_en = 1'b1;
            end
        end
        disp_en = 1'b0;
        nvec++;
        if (frame !== 1'b1) begin
            nerr++;
            $display("FAIL %s frame_timeout: frame=%b expected 1 within 3000 cycles", name, frame);
        end
        nvec++;
        if (fb_bank !== bank) begin
            nerr++;
            $display("FAIL %s fb_bank: got %b expected %b", name, fb_bank, bank);
        end
        nvec++;
        if (rom_img_addr !== ROM_BASE || fb_addr !== next_base) begin
            nerr++;
            $display("FAIL %s rewind: rom %h fb %h expected rom %h fb %h", name, rom_img_addr, fb_addr, ROM_BASE, next_base);
        end
        @(negedge clk_sys);
        nvec++;
        if (frame !== 1'b0) begin
            nerr++;
            $display("FAIL %s frame_pulse: frame=%b one cycle later, expected 0", name, frame);
        end
        nw = wr_addr_q.size() - base_w;
        nvec++;
        if (nw !== NWORDS) begin
            nerr++;
            $display("FAIL %s word_count: got %0d expected %0d", name, nw, NWORDS);
        end
        for (int k = 0; k < NWORDS && k < nw; k++) begin
            exp_w = '0;
            for (int j = 0; j < FB_BYTES; j++) exp_w[8*j +: 8] = pix[FB_BYTES*k + j];
            nvec++;
            if (wr_addr_q[base_w+k] !== bank_base + 28'(FB_BYTES*k)) begin
                nerr++;
                $display("FAIL %s fb_addr[%0d]: got %h expected %h", name, k, wr_addr_q[base_w+k], bank_base + 28'(FB_BYTES*k));
            end
            nvec++;
            if (wr_data_q[base_w+k] !== exp_w) begin
                nerr++;
                $display("FAIL %s fb_data[%0d]: got %h expected %h", name, k, wr_data_q[base_w+k], exp_w);
            end
        end
        nr = rd_addr_q.size() - base_r;
        nvec++;
        if (nr !== exp_r.size()) begin
            nerr++;
            $display("FAIL %s rom_reads: got %0d expected %0d", name, nr, exp_r.size());
        end
        for (int i = 0; i < nr && i < exp_r.size(); i++) begin
            nvec++;
            if (rd_addr_q[base_r+i] !== exp_r[i]) begin
                nerr++;
                $display("FAIL %s rom_addr[%0d]: got %h expected %h", name, i, rd_addr_q[base_r+i], exp_r[i]);
            end
        end
        nvec++;
        if (unstable_cnt !== unst0) begin
            nerr++;
            $display("FAIL %s fb_stable: %0d changes while fb_req high, expected 0", name, unstable_cnt - unst0);
        end
        if (mode == 2) begin
            nvec++;
            if (nw < 1 || held_q[base_w] !== 10) begin
                nerr++;
                $display("FAIL %s fb_req_held: got %0d cycles expected 10", name, (nw < 1) ? -1 : held_q[base_w]);
            end
            slow_idx = -1;
        end
    endtask

    task automatic test_reset();
        bit read_seen;
        for (int i = 0; i < 4; i++) begin
            m_row_a[i] = '0; m_row_b[i] = '0; m_row_s[i] = 1'b0;
        end
        reset_n = 1'b0;
        disp_en = 1'b1;
        read_seen = 0;
        repeat (3) begin
            @(negedge clk_sys);
            if (rom_img_read !== 1'b0) read_seen = 1;
        end
        nvec++;
        if (read_seen) begin
            nerr++;
            $display("FAIL reset_reads: rom_img_read seen during reset, expected none");
        end
        nvec++;
        if (fb_req !== 1'b0 || frame !== 1'b0 || fb_bank !== 1'b0) begin
            nerr++;
            $display("FAIL reset_ctrl: fb_req=%b frame=%b fb_bank=%b expected 0 0 0", fb_req, frame, fb_bank);
        end
        nvec++;
        if (rom_img_addr !== ROM_BASE) begin
            nerr++;
            $display("FAIL reset_rom_addr: got %h expected %h", rom_img_addr, ROM_BASE);
        end
        nvec++;
        if (fb_addr !== 28'h0 || fb_data !== 64'h0) begin
            nerr++;
            $display("FAIL reset_fb: addr %h data %h expected 0 0", fb_addr, fb_data);
        end
        disp_en = 1'b0;
        reset_n = 1'b1;
        repeat (3) @(negedge clk_sys);
    endtask

    task automatic test_plain_frame();
        for (int p = 0; p < TOTAL; p++) begin
            rom[2*p]   = {2'b11, 6'($urandom)};
            rom[2*p+1] = 8'(p);
        end
        run_frame("plain", 0);
        nvec++;
        if (wr_data_q.size() < 2 || wr_data_q[0] !== 64'h0706050403020100 || wr_data_q[1] !== 64'h0F0E0D0C0B0A0908) begin
            nerr++;
            $display("FAIL plain_words: got %h %h expected 0706050403020100 0F0E0D0C0B0A0908",
                     (wr_data_q.size() > 0) ? wr_data_q[0] : 64'hx, (wr_data_q.size() > 1) ? wr_data_q[1] : 64'hx);
        end
    endtask

    task automatic test_lit_pixel();
        strobe(4'b0010, 16'h0008, 16'h0000, 1'b0);
        for (int p = 0; p < TOTAL; p++) begin
            rom[2*p]   = {2'b11, 6'($urandom)};
            rom[2*p+1] = 8'($urandom);
        end
        rom[0]  = 8'h0D;
        rom[6]  = 8'h0D;
        rom[10] = 8'h0C;
        rom[20] = 8'h4D;
        run_frame("lit", 0);
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < 4; r++) strobe(4'(1 << r), 16'($urandom), 16'($urandom), 1'($urandom));
            strobe(4'b0011, 16'($urandom), 16'($urandom), 1'($urandom));
            strobe(4'b0000, 16'($urandom), 16'($urandom), 1'($urandom));
            for (int p = 0; p < 2*TOTAL; p++) rom[p] = 8'($urandom);
            run_frame("random", 0);
        end
        mid_row = $urandom_range(0, 3);
        for (int p = 0; p < 2*TOTAL; p++) rom[p] = 8'($urandom);
        for (int p = 0; p < 4; p++) rom[2*p] = {2'b01, 4'($urandom), 2'(mid_row)};
        run_frame("mid_change", 1);
        run_frame("after_change", 0);
    endtask

    task automatic test_back_to_back_drop();
        for (int p = 0; p < 2*TOTAL; p++) rom[p] = 8'($urandom);
        run_frame("ack_delay_drop", 2);
        run_frame("after_drop", 0);
    endtask

    initial begin
        test_reset();
        test_plain_frame();
        test_lit_pixel();
        test_random_frames();
        test_back_to_back_drop();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
